// File: rtl/spi_master_if.sv
// Bundles the host-side control/data signals and the SPI pads of spi_master.
// The master modport is the controller's view; slave is the host/bench view.
interface spi_master_if #(
  parameter int MAX_LEN = 128,
  parameter int SS_NB   = 32
);
  logic               go;
  logic [15:0]        divider;
  logic [6:0]         char_len;
  logic               tx_neg;
  logic               rx_neg;
  logic               lsb;
  logic [SS_NB-1:0]   ss;
  logic [MAX_LEN-1:0] tx_data;
  logic [MAX_LEN-1:0] rx_data;
  logic               busy;
  logic               done;
  logic               sclk_pad_o;
  logic               mosi_pad_o;
  logic               miso_pad_i;
  logic [SS_NB-1:0]   ss_pad_o;

  modport master (
    input  go, divider, char_len, tx_neg, rx_neg, lsb, ss, tx_data, miso_pad_i,
    output rx_data, busy, done, sclk_pad_o, mosi_pad_o, ss_pad_o
  );

  modport slave (
    output go, divider, char_len, tx_neg, rx_neg, lsb, ss, tx_data, miso_pad_i,
    input  rx_data, busy, done, sclk_pad_o, mosi_pad_o, ss_pad_o
  );
endinterface

// File: rtl/spi_master.sv
// SPI master: one transfer of 1..MAX_LEN bits per go, programmable sclk divider,
// independent tx/rx edge selection, LSB/MSB first, active-low slave selects.
//
// state | meaning
// IDLE  | waiting for go; pads idle, mosi holds its last value
// XFER  | shifting; ends on the N-th sclk falling edge
module spi_master #(
  parameter int MAX_LEN = 128,
  parameter int SS_NB   = 32
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  spi_master_if.master bus
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [15:0]        div_q, div_cnt;
  logic [CW-1:0]      len_q, fall_cnt, len_in;
  logic               tx_neg_q, rx_neg_q, lsb_q;
  logic [MAX_LEN-1:0] tx_word, rx_acc, rx_acc_nxt, rx_q;
  logic [PW-1:0]      tx_pos, tx_pos_nxt, rx_pos, rx_pos_nxt, first_pos;
  logic               sclk_q, mosi_q, done_q;
  logic [SS_NB-1:0]   ss_pad_q;
  logic               start, tick, rise, fall, last_fall, tx_edge, rx_edge;

  assign len_in    = (bus.char_len == 7'd0) ? CW'(MAX_LEN) : CW'(bus.char_len);
  assign first_pos = bus.lsb ? '0 : PW'(len_in - CW'(1));

  // sclk toggles when the divider down-counter reaches terminal count
  assign tick      = (state_q == XFER) && (div_cnt == 16'd0);
  assign rise      = tick && !sclk_q;
  assign fall      = tick && sclk_q;
  assign last_fall = fall && (fall_cnt == len_q - CW'(1));

  // bit 0 is driven at start, so the first rising edge never shifts mosi
  assign tx_edge    = tx_neg_q ? (fall && !last_fall) : (rise && (fall_cnt != '0));
  assign rx_edge    = rx_neg_q ? fall : rise;
  assign tx_pos_nxt = lsb_q ? tx_pos + PW'(1) : tx_pos - PW'(1);
  assign rx_pos_nxt = lsb_q ? rx_pos + PW'(1) : rx_pos - PW'(1);

  always_comb begin
    rx_acc_nxt = rx_acc;
    if (rx_edge) rx_acc_nxt[rx_pos] = bus.miso_pad_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // go coinciding with the done pulse is deliberately refused
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: if (bus.go && !done_q) begin
        start   = 1'b1;
        state_d = XFER;
      end
      XFER: if (last_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_q    <= '0;
      div_cnt  <= '0;
      len_q    <= '0;
      fall_cnt <= '0;
      tx_neg_q <= 1'b0;
      rx_neg_q <= 1'b0;
      lsb_q    <= 1'b0;
      tx_word  <= '0;
      rx_acc   <= '0;
      rx_q     <= '0;
      tx_pos   <= '0;
      rx_pos   <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      ss_pad_q <= '1;
    end else begin
      done_q <= last_fall;
      if (start) begin
        div_q    <= bus.divider;
        div_cnt  <= bus.divider;
        len_q    <= len_in;
        fall_cnt <= '0;
        tx_neg_q <= bus.tx_neg;
        rx_neg_q <= bus.rx_neg;
        lsb_q    <= bus.lsb;
        tx_word  <= bus.tx_data;
        tx_pos   <= first_pos;
        rx_pos   <= first_pos;
        rx_acc   <= '0;
        sclk_q   <= 1'b0;
        mosi_q   <= bus.tx_data[first_pos];
        ss_pad_q <= ~bus.ss;
      end else if (state_q == XFER) begin
        if (tick) begin
          sclk_q  <= ~sclk_q;
          div_cnt <= div_q;
          if (fall) fall_cnt <= fall_cnt + CW'(1);
        end else begin
          div_cnt <= div_cnt - 16'd1;
        end
        if (tx_edge) begin
          tx_pos <= tx_pos_nxt;
          mosi_q <= tx_word[tx_pos_nxt];
        end
        if (rx_edge) rx_pos <= rx_pos_nxt;
        rx_acc <= rx_acc_nxt;
        if (last_fall) begin
          rx_q     <= rx_acc_nxt;
          ss_pad_q <= '1;
        end
      end
    end
  end

  assign bus.busy       = (state_q == XFER);
  assign bus.done       = done_q;
  assign bus.sclk_pad_o = sclk_q;
  assign bus.mosi_pad_o = mosi_q;
  assign bus.ss_pad_o   = ss_pad_q;
  assign bus.rx_data    = rx_q;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench for spi_master: stimulus pushes expected transfer results,
// a monitor pops them on done and checks data, timing, edge counts and pad behaviour.
module tb_spi_master;
  localparam int ML = 128;
  localparam int SN = 32;
  localparam logic [SN-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miso_one = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.MAX_LEN(ML), .SS_NB(SN)) bus ();
  assign bus.miso_pad_i = miso_one ? 1'b1 : bus.mosi_pad_o;

  spi_master #(.MAX_LEN(ML), .SS_NB(SN)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus.master)
  );

  typedef struct {
    logic [ML-1:0] rx;
    logic [SN-1:0] ssx;
    int            n;
    int            lat;
    int            t0;
    logic          txn;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rises = 0;
  int   falls = 0;
  int   done_cnt = 0;
  logic prev_busy = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;

  function automatic void chk(input string nm, input logic [ML-1:0] act, input logic [ML-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  // monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (bus.busy && !prev_busy) begin
        rises = 0;
        falls = 0;
      end
      if (bus.sclk_pad_o && !prev_sclk) rises++;
      if (!bus.sclk_pad_o && prev_sclk) falls++;
      if (bus.busy && sbq.size() > 0)
        chk("ss_pad_busy", ML'(bus.ss_pad_o), ML'(sbq[0].ssx));
      if (prev_busy && (bus.mosi_pad_o !== prev_mosi) && sbq.size() > 0)
        chk("mosi_edge", ML'(sbq[0].txn ? (prev_sclk && !bus.sclk_pad_o)
                                         : (!prev_sclk && bus.sclk_pad_o)), ML'(1));
      if (bus.done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 with nothing outstanding, required done=0");
        end else begin
          e = sbq.pop_front();
          chk("rx_data", bus.rx_data, e.rx);
          chk("done_latency", ML'(cyc - e.t0), ML'(e.lat));
          chk("sclk_rises", ML'(rises), ML'(e.n));
          chk("sclk_falls", ML'(falls), ML'(e.n));
          chk("busy_at_done", ML'(bus.busy), ML'(0));
          chk("ss_at_done", ML'(bus.ss_pad_o), ML'(ALL1));
          chk("sclk_at_done", ML'(bus.sclk_pad_o), ML'(0));
        end
      end
    end
    prev_busy = bus.busy;
    prev_sclk = bus.sclk_pad_o;
    prev_mosi = bus.mosi_pad_o;
  end

  task automatic start_xfer(input logic [ML-1:0] tx, input logic [6:0] cl, input logic [15:0] d,
                            input logic txn, input logic rxn, input logic lb,
                            input logic [SN-1:0] s, input logic m1);
    exp_t          e;
    int            n;
    logic [ML-1:0] mask;
    logic [SN-1:0] ns;
    n = (cl == 7'd0) ? 128 : int'(cl);
    mask = '0;
    for (int i = 0; i < n; i++) mask[i] = 1'b1;
    ns = ~s;
    @(negedge clk);
    miso_one     = m1;
    bus.go       = 1'b1;
    bus.tx_data  = tx;
    bus.char_len = cl;
    bus.divider  = d;
    bus.tx_neg   = txn;
    bus.rx_neg   = rxn;
    bus.lsb      = lb;
    bus.ss       = s;
    e.rx  = m1 ? mask : (tx & mask);
    e.ssx = ns;
    e.n   = n;
    e.lat = 2 * n * (int'(d) + 1);
    e.t0  = cyc + 1;
    e.txn = txn;
    sbq.push_back(e);
    @(negedge clk);
    bus.go = 1'b0;
    chk("busy_start", ML'(bus.busy), ML'(1));
    chk("ss_start", ML'(bus.ss_pad_o), ML'(ns));
    chk("mosi_first", ML'(bus.mosi_pad_o), ML'(lb ? tx[0] : tx[n-1]));
    // scramble inputs: the transfer must run on the latched copy
    bus.tx_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.divider  = 16'($urandom());
    bus.char_len = 7'($urandom());
    bus.tx_neg   = 1'($urandom());
    bus.rx_neg   = 1'($urandom());
    bus.lsb      = 1'($urandom());
    bus.ss       = $urandom();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.done && k < budget);
    if (!bus.done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", budget);
    end
  endtask

  initial begin
    logic          tn, rn;
    int            k, dc;
    bus.go = 1'b0;
    bus.divider = '0;
    bus.char_len = '0;
    bus.tx_neg = 1'b0;
    bus.rx_neg = 1'b0;
    bus.lsb = 1'b0;
    bus.ss = '0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", ML'(bus.busy), ML'(0));
    chk("rst_done", ML'(bus.done), ML'(0));
    chk("rst_sclk", ML'(bus.sclk_pad_o), ML'(0));
    chk("rst_mosi", ML'(bus.mosi_pad_o), ML'(0));
    chk("rst_ss", ML'(bus.ss_pad_o), ML'(ALL1));
    chk("rst_rx", bus.rx_data, '0);
    rst = 1'b0;

    start_xfer(ML'(8'hA5), 7'd8, 16'd0, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0);
    wait_done(100);
    start_xfer(ML'(8'h01), 7'd8, 16'd3, 1'b1, 1'b0, 1'b1, $urandom(), 1'b0);
    wait_done(200);
    start_xfer({$urandom(), $urandom(), $urandom(), $urandom()}, 7'd0, 16'd0,
               1'b1, 1'b0, 1'b0, $urandom(), 1'b1);
    wait_done(400);
    start_xfer(ML'(8'h3C), 7'd8, 16'd1, 1'b0, 1'b1, 1'b0, $urandom(), 1'b0);
    wait_done(100);
    start_xfer({$urandom(), $urandom(), $urandom(), $urandom()}, 7'd12, 16'd2,
               1'b1, 1'b1, 1'b1, '0, 1'b0);
    wait_done(200);

    // go mid-transfer and in the done cycle must both be ignored
    start_xfer({$urandom(), $urandom(), $urandom(), $urandom()}, 7'd16, 16'd1,
               1'b0, 1'b1, 1'b1, $urandom(), 1'b0);
    repeat (20) @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    wait_done(200);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    chk("go_in_done_ignored", ML'(bus.busy), ML'(0));

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 2))
        0:       begin tn = 1'b1; rn = 1'b0; end
        1:       begin tn = 1'b0; rn = 1'b1; end
        default: begin tn = 1'b1; rn = 1'b1; end
      endcase
      start_xfer({$urandom(), $urandom(), $urandom(), $urandom()}, 7'($urandom_range(0, 127)),
                 16'($urandom_range(0, 3)), tn, rn, 1'($urandom_range(0, 1)), $urandom(),
                 ($urandom_range(0, 7) == 0));
      wait_done(1100);
    end

    // abort mid-transfer with reset after three sclk pulses
    start_xfer({$urandom(), $urandom(), $urandom(), $urandom()}, 7'd16, 16'd1,
               1'b1, 1'b0, 1'b0, $urandom(), 1'b0);
    k = 0;
    while (falls < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_3_pulses", ML'(falls >= 3), ML'(1));
    rst = 1'b1;
    sbq.delete();
    dc = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", ML'(bus.busy), ML'(0));
    chk("abort_sclk", ML'(bus.sclk_pad_o), ML'(0));
    chk("abort_ss", ML'(bus.ss_pad_o), ML'(ALL1));
    chk("abort_rx", bus.rx_data, '0);
    chk("abort_done", ML'(bus.done), ML'(0));
    repeat (100) @(negedge clk);
    chk("abort_no_done", ML'(done_cnt), ML'(dc));
    chk("abort_rx_held", bus.rx_data, '0);

    chk("scoreboard_drained", ML'(sbq.size()), ML'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
